// File: rtl/regfile_sb_if.sv
// regfile_sb_if
//   Bundles the decode/issue and writeback signals of the scoreboarded
//   register file.
//   master: decode/issue + writeback side. It drives the addresses, the write
//           data and the control signals, and it samples the read data and
//           the status outputs.
//   slave : the register file itself.
//   Signals:
//     rd_addr    NRD*AW    read addresses, port i at [i*AW +: AW]
//     rd_data    NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
//     rd_busy    NRD       register read by port i has a pending write
//     wb_en/wb_addr/wb_data  writeback port
//     iss_en/iss_addr        destination reservation request
//     iss_ready              reservation would be accepted this cycle
//     flush                  clear all reservations at the next edge
//     busy_count AW+1      number of reserved registers
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                iss_ready;
    logic                flush;
    logic [AW:0]         busy_count;

    modport master (
        output rd_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, iss_ready, busy_count
    );

    modport slave (
        input  rd_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, iss_ready, busy_count
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb
//   Integer register file with a pending-write scoreboard. Each register has
//   one busy bit. The bit is set when decode reserves the register as a
//   destination, and it is cleared when the register is written back or when
//   the pipeline is flushed. The module has NRD combinational read ports,
//   each with optional same-cycle writeback forwarding, and one writeback
//   port.
//   Ports:
//     clk   rising-edge clock
//     rstb  asynchronous, active-low reset
//     bus   regfile_sb_if.slave (read ports, writeback, issue, flush, status)
//   Parameters:
//     XLEN     data width
//     AW       address width (2**AW registers)
//     NRD      number of read ports
//     BYPASS   forward a same-cycle writeback to matching read ports
//     ZERO_REG register 0 is hardwired to zero and is never busy
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input logic         clk,
    input logic         rstb,
    regfile_sb_if.slave bus
);
    localparam int NREG = 2 ** AW;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     busy_count;
    logic [AW:0]     busy_count_next;
    logic            wb_writable;
    logic            iss_accept;
    logic [NRD*XLEN-1:0] rd_data_v;
    logic [NRD-1:0]      rd_busy_v;

    // Register 0 behaves as a constant when ZERO_REG is set.
    function automatic logic writable(input logic [AW-1:0] addr);
        return !(ZERO_REG && (addr == '0));
    endfunction

    assign wb_writable = bus.wb_en && writable(bus.wb_addr);

    // A register that is being written back in this cycle is free for a new
    // reservation, so back-to-back reuse of a destination does not stall.
    assign bus.iss_ready = !busy[bus.iss_addr] ||
                           (bus.wb_en && (bus.wb_addr == bus.iss_addr));

    // An issue to the zero register is accepted, but it reserves nothing.
    assign iss_accept = bus.iss_en && bus.iss_ready && !bus.flush &&
                        writable(bus.iss_addr);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_writable) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Priority from lowest to highest: writeback clears the bit, a new
    // reservation on the same address sets it again, and flush wipes every
    // bit.
    always_comb begin
        busy_next = busy;
        if (wb_writable) begin
            busy_next[bus.wb_addr] = 1'b0;
        end
        if (iss_accept) begin
            busy_next[bus.iss_addr] = 1'b1;
        end
        if (bus.flush) begin
            busy_next = '0;
        end
    end

    always_comb begin
        busy_count_next = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_count_next = busy_count_next + {{AW{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= busy_count_next;
        end
    end

    assign bus.busy_count = busy_count;

    // Each read port forwards a same-cycle writeback when BYPASS is set. The
    // forwarded value also hides the busy bit that the writeback is about to
    // clear.
    always_comb begin
        rd_data_v = '0;
        rd_busy_v = '0;
        for (int p = 0; p < NRD; p++) begin
            if (BYPASS && wb_writable &&
                (bus.rd_addr[p*AW +: AW] == bus.wb_addr)) begin
                rd_data_v[p*XLEN +: XLEN] = bus.wb_data;
                rd_busy_v[p]              = 1'b0;
            end else begin
                rd_data_v[p*XLEN +: XLEN] = regs[bus.rd_addr[p*AW +: AW]];
                rd_busy_v[p]              = busy[bus.rd_addr[p*AW +: AW]];
            end
            if (!writable(bus.rd_addr[p*AW +: AW])) begin
                rd_data_v[p*XLEN +: XLEN] = '0;
                rd_busy_v[p]              = 1'b0;
            end
        end
    end

    assign bus.rd_data = rd_data_v;
    assign bus.rd_busy = rd_busy_v;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
//   Self-checking bench for regfile_sb in its default configuration
//   (BYPASS=1, ZERO_REG=1). The reference model keeps the register contents
//   in an array and the reservations in a bit vector. It derives every
//   expected output from the architectural rules of the register file.
//   Directed scenarios come first, followed by a randomized phase.
module tb_regfile_sb;
    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NRD      = 2;
    localparam int NREG     = 2 ** AW;
    localparam bit BYPASS   = 1'b1;
    localparam bit ZERO_REG = 1'b1;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [XLEN-1:0] model_regs [NREG];
    logic [NREG-1:0] model_busy;

    regfile_sb_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus ();

    regfile_sb #(
        .XLEN(XLEN), .AW(AW), .NRD(NRD), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk (clk),
        .rstb(rstb),
        .bus (bus)
    );

    // 10-unit clock. Rising edges fall at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Single comparison point. It counts every comparison and reports any
    // mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    function automatic bit mWritable(input int a);
        return !(ZERO_REG && a == 0);
    endfunction

    function automatic bit mHit(input int a);
        return BYPASS && bus.wb_en && (a == int'(bus.wb_addr)) && mWritable(a);
    endfunction

    function automatic logic [XLEN-1:0] mRead(input int a);
        if (!mWritable(a)) return '0;
        if (mHit(a)) return bus.wb_data;
        return model_regs[a];
    endfunction

    function automatic bit mBusy(input int a);
        return mWritable(a) && model_busy[a] && !mHit(a);
    endfunction

    function automatic bit mReady();
        return !model_busy[bus.iss_addr] ||
               (bus.wb_en && bus.wb_addr == bus.iss_addr);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NREG; i++) model_regs[i] = '0;
        model_busy = '0;
    endtask

    // Compares every combinational and registered output with the model.
    task automatic checkAll();
        for (int p = 0; p < NRD; p++) begin
            checkOutput($sformatf("rd_data%0d", p),
                        64'(bus.rd_data[p*XLEN +: XLEN]),
                        64'(mRead(int'(bus.rd_addr[p*AW +: AW]))));
            checkOutput($sformatf("rd_busy%0d", p),
                        64'(bus.rd_busy[p]),
                        64'(mBusy(int'(bus.rd_addr[p*AW +: AW]))));
        end
        checkOutput("iss_ready", 64'(bus.iss_ready), 64'(mReady()));
        checkOutput("busy_count", 64'(bus.busy_count), 64'($countones(model_busy)));
    endtask

    task automatic setInputs(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                             input logic we, input logic [AW-1:0] wa,
                             input logic [XLEN-1:0] wd, input logic ie,
                             input logic [AW-1:0] ia, input logic fl);
        bus.rd_addr  = {r1, r0};
        bus.wb_en    = we;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        bus.iss_en   = ie;
        bus.iss_addr = ia;
        bus.flush    = fl;
    endtask

    // Drives one cycle of inputs and checks the outputs before the edge.
    task automatic applyStimulus(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                                 input logic we, input logic [AW-1:0] wa,
                                 input logic [XLEN-1:0] wd, input logic ie,
                                 input logic [AW-1:0] ia, input logic fl);
        setInputs(r0, r1, we, wa, wd, ie, ia, fl);
        #2;
        checkAll();
    endtask

    // Applies the architectural effect of the current inputs to the model,
    // then advances past the rising edge.
    task automatic stepClock();
        bit accept;
        accept = bus.iss_en && mReady() && !bus.flush;
        if (bus.wb_en && mWritable(int'(bus.wb_addr))) begin
            model_regs[bus.wb_addr] = bus.wb_data;
            model_busy[bus.wb_addr] = 1'b0;
        end
        if (accept && mWritable(int'(bus.iss_addr))) model_busy[bus.iss_addr] = 1'b1;
        if (bus.flush) model_busy = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        modelReset();
        setInputs('0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        #12 rstb = 1'b1;
        @(posedge clk);
        #1;

        // Reset state, sweeping every address on both ports.
        for (int a = 0; a < NREG; a++) begin
            applyStimulus(AW'(a), AW'(NREG - 1 - a), 1'b0, '0, '0, 1'b0, AW'(a), 1'b0);
            checkOutput("reset_rd_data", 64'(bus.rd_data[XLEN-1:0]), 64'd0);
            stepClock();
        end

        // Same-cycle write-through, then a write to the zero register.
        applyStimulus(5, 5, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0);
        checkOutput("bypass_5", 64'(bus.rd_data[XLEN-1:0]), 64'hDEADBEEF);
        stepClock();
        applyStimulus(5, 0, 1'b1, 0, 32'h1234, 1'b0, 0, 1'b0);
        checkOutput("stored_5", 64'(bus.rd_data[XLEN-1:0]), 64'hDEADBEEF);
        checkOutput("zero_wr_bypass", 64'(bus.rd_data[2*XLEN-1:XLEN]), 64'd0);
        stepClock();
        applyStimulus(0, 0, 1'b0, 0, '0, 1'b0, 0, 1'b0);
        checkOutput("zero_after_wr", 64'(bus.rd_data[XLEN-1:0]), 64'd0);
        stepClock();

        // Reserve 7, reject a duplicate reservation, then write back 7.
        applyStimulus(7, 7, 1'b0, 0, '0, 1'b1, 7, 1'b0);
        stepClock();
        applyStimulus(7, 7, 1'b0, 0, '0, 1'b1, 7, 1'b0);
        checkOutput("dup_iss_ready", 64'(bus.iss_ready), 64'd0);
        checkOutput("busy7", 64'(bus.rd_busy[0]), 64'd1);
        checkOutput("count_7", 64'(bus.busy_count), 64'd1);
        stepClock();
        applyStimulus(7, 7, 1'b1, 7, 32'hA5, 1'b0, 7, 1'b0);
        checkOutput("wb7_busy_bypass", 64'(bus.rd_busy[0]), 64'd0);
        checkOutput("wb7_count_pre", 64'(bus.busy_count), 64'd1);
        stepClock();
        applyStimulus(7, 7, 1'b0, 0, '0, 1'b0, 7, 1'b0);
        checkOutput("wb7_count_post", 64'(bus.busy_count), 64'd0);
        stepClock();

        // Writeback and reservation of register 9 on the same edge.
        applyStimulus(9, 9, 1'b1, 9, 32'h55, 1'b1, 9, 1'b0);
        checkOutput("same_edge_ready", 64'(bus.iss_ready), 64'd1);
        stepClock();
        applyStimulus(9, 9, 1'b0, 0, '0, 1'b0, 9, 1'b0);
        checkOutput("r9_data", 64'(bus.rd_data[XLEN-1:0]), 64'h55);
        checkOutput("r9_busy", 64'(bus.rd_busy[0]), 64'd1);
        checkOutput("r9_count", 64'(bus.busy_count), 64'd1);
        stepClock();

        // Flush wins over a same-edge issue and still lets the writeback
        // through.
        applyStimulus(1, 2, 1'b0, 0, '0, 1'b1, 1, 1'b1);
        stepClock();
        for (int r = 1; r <= 3; r++) begin
            applyStimulus(AW'(r), AW'(r), 1'b0, 0, '0, 1'b1, AW'(r), 1'b0);
            stepClock();
        end
        applyStimulus(4, 2, 1'b1, 2, 32'h77, 1'b1, 4, 1'b1);
        checkOutput("pre_flush_count", 64'(bus.busy_count), 64'd3);
        stepClock();
        applyStimulus(4, 2, 1'b0, 0, '0, 1'b0, 4, 1'b0);
        checkOutput("flush_count", 64'(bus.busy_count), 64'd0);
        checkOutput("flush_r4_busy", 64'(bus.rd_busy[0]), 64'd0);
        checkOutput("flush_r2_data", 64'(bus.rd_data[2*XLEN-1:XLEN]), 64'h77);
        stepClock();

        // Asynchronous reset asserted between clock edges.
        applyStimulus(10, 11, 1'b0, 0, '0, 1'b1, 10, 1'b0);
        stepClock();
        applyStimulus(10, 11, 1'b1, 11, 32'hFF, 1'b0, 10, 1'b0);
        stepClock();
        applyStimulus(11, 10, 1'b0, 0, '0, 1'b0, 10, 1'b0);
        rstb = 1'b0;
        #1;
        checkOutput("arst_r11_data", 64'(bus.rd_data[XLEN-1:0]), 64'd0);
        checkOutput("arst_r10_busy", 64'(bus.rd_busy[1]), 64'd0);
        checkOutput("arst_count", 64'(bus.busy_count), 64'd0);
        checkOutput("arst_ready", 64'(bus.iss_ready), 64'd1);
        modelReset();
        #1 rstb = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(11, 10, 1'b0, 0, '0, 1'b0, 10, 1'b0);
        stepClock();

        // Randomized traffic. Addresses are kept in a small window so that
        // collisions between the ports are frequent.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                          XLEN'($urandom), 1'($urandom_range(0, 1)),
                          AW'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
            stepClock();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
